aes128_enc_iter: RTL and testbench
==================================

# aes128_enc_iter

Iterative AES-128 encryption core with valid/ready handshakes and on-the-fly key expansion, configurable to apply 1, 2, 5 or 10 rounds per clock. It builds on the team's single-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey, with MixColumns skipped in round 10). It adds state, a round counter, key scheduling and flow control. It sits between the block source (host/UART front end) and the ciphertext sink.

## Interface
Parameters:
- UNROLL, default 1: rounds computed per clock. Legal values are 1, 2, 5 and 10; any other value is an elaboration error.
- NITER, derived as 10/UNROLL: number of compute cycles per block.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: plaintext/key pair offered.
- in_ready, output, 1: core can accept a block.
- in_pt, input, 128: plaintext; bit 127 is FIPS-197 byte 0.
- in_key, input, 128: cipher key, same byte order.
- out_valid, output, 1: ciphertext available.
- out_ready, input, 1: sink accepts ciphertext.
- out_ct, output, 128: ciphertext, same byte order.
- busy, output, 1: high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: state_reg ← in_pt ^ in_key (round-0 AddRoundKey), rk_reg ← in_key, rnd ← 1. Go to RUN.
- RUN:
  - Each cycle applies UNROLL chained rounds r = rnd … rnd+UNROLL−1.
  - For each round r: rk_r = keystep(rk_{r−1}, RCON[r]), then state = AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk_r).
  - Round 10 omits MixColumns.
  - rnd ← rnd+UNROLL.
  - When the final round (10) is computed, latch the result into out_ct and go to DONE.
- DONE:
  - out_valid=1. out_ct is held stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE.
- in_ready is 0 in RUN and DONE. Inputs offered then are ignored and not captured, and in_pt/in_key are not sampled.
- keystep(w): temp = SubWord(RotWord(w[31:0])) ^ {RCON,24'h0}; w0' = w[127:96]^temp; w1' = w[95:64]^w0'; w2' = w[63:32]^w1'; w3' = w[31:0]^w2'.
- RCON[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- rnd is 4 bits wide and never exceeds 10. There is no wrap-around; the RUN exit is decided on rnd+UNROLL−1 == 10.
- Reset in any state, including mid-RUN: go to IDLE and discard the in-flight block.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, busy=0, out_ct=0, rnd=0, state_reg=0, rk_reg=0.
- Accept occurs at edge T when in_valid && in_ready.
- out_valid rises after edge T+NITER: 10 cycles for UNROLL=1, 5 for 2, 2 for 5, 1 for 10.
- Output handshake completes at the first edge where out_valid && out_ready. out_valid falls and in_ready rises after that edge.
- The next accept is possible at the following edge. Throughput is one block per NITER+2 cycles with out_ready tied high.
- out_ready asserted before out_valid has no effect.
- Simultaneous rst and handshake: rst wins.
- Critical path is UNROLL rounds plus UNROLL key steps. UNROLL=10 is for reduced-clock parts only.

## Structure
- Package aes_pkg holds:
  - NR=10
  - RCON table (10×8)
  - state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - S-box function, shared by SubBytes and SubWord
- Sub-module aes_key_step (128-bit rk in, 8-bit rcon in, 128-bit rk out, combinational), instantiated UNROLL times.
- The round datapath reuses the team's existing SubBytes, ShiftRows and MixColumns modules inside a generate loop of UNROLL stages. The last-round MixColumns bypass is selected by absolute round index.

## Test plan
- FIPS-197 C.1, UNROLL=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → out_ct 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid exactly 10 cycles after accept.
- FIPS-197 B, repeated for UNROLL=2, 5 and 10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32, with latency 5, 2 and 1 cycles respectively.
- All-zero key and pt → 66e94bd4ef8a2c3b884cfa59ca342b2e. Hold out_ready=0 for 7 cycles: out_ct stable, in_ready=0, and a new in_valid is ignored. Then out_ready=1 → in_ready=1 on the next cycle.
- Back-to-back: three C.1/B/zero blocks with in_valid held high and out_ready=1 → correct ciphertexts in order, one block every NITER+2 cycles.
- Assert rst at RUN cycle 4 (UNROLL=1) → next cycle out_valid=0, busy=0, in_ready=1. A fresh C.1 block then yields the correct result with no residue.
- rst asserted together with in_valid in IDLE → block not accepted; out_valid stays 0 for 12 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and byte-level helpers.
package aes_pkg;

    localparam int NR = 10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } fsm_state_t;

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    // Rounds outside 1..10 only occur while the datapath is idle; return 0 there.
    function automatic logic [7:0] rcon_of(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) begin
            return RCON[r];
        end
        return 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: previous round key in, next round key out.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rk,
    input  logic [7:0]   rcon,
    output logic [127:0] rk_next
);

    logic [31:0] rot;
    logic [31:0] temp;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;

    assign rot  = {rk[23:0], rk[31:24]};
    assign temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign w0   = rk[127:96] ^ temp;
    assign w1   = rk[95:64] ^ w0;
    assign w2   = rk[63:32] ^ w1;
    assign w3   = rk[31:0] ^ w2;

    assign rk_next = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_mix_columns.sv
// MixColumns: each 4-byte column multiplied by the fixed {02,03,01,01} circulant.
module aes_mix_columns
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;

        assign a0 = din[127-32*c -: 8];
        assign a1 = din[119-32*c -: 8];
        assign a2 = din[111-32*c -: 8];
        assign a3 = din[103-32*c -: 8];

        assign dout[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign dout[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign dout[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign dout[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

endmodule

// File: rtl/aes_shift_rows.sv
// ShiftRows: row r of the column-major state rotates left by r bytes.
module aes_shift_rows (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end

endmodule

// File: rtl/aes_sub_bytes.sv
// SubBytes: S-box applied to each of the 16 state bytes.
module aes_sub_bytes
    import aes_pkg::*;
(
    input  logic [127:0] din,
    output logic [127:0] dout
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[127-8*i -: 8] = sbox(din[127-8*i -: 8]);
    end

endmodule

// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryptor, UNROLL rounds per clock, key expanded on the fly.
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_pt,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_ct,
    output logic         busy
);

    localparam int NITER = NR / UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10) || NITER * UNROLL != NR) begin : g_bad_unroll
        $fatal(1, "aes128_enc_iter: UNROLL must be 1, 2, 5 or 10");
    end

    fsm_state_t   state;
    fsm_state_t   state_next;
    logic [127:0] state_reg;
    logic [127:0] rk_reg;
    logic [3:0]   rnd;
    logic         load;
    logic         step;
    logic         finish;
    logic         last_step;

    logic [127:0] st_chain [0:UNROLL];
    logic [127:0] rk_chain [0:UNROLL];

    assign st_chain[0] = state_reg;
    assign rk_chain[0] = rk_reg;

    // The final round of a block lands in the last stage of the cycle it is computed in.
    assign last_step = (rnd + 4'(UNROLL - 1)) == 4'(NR);

    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        logic [3:0]   r_idx;
        logic [7:0]   rcon;
        logic [127:0] sb;
        logic [127:0] sr;
        logic [127:0] mc;

        assign r_idx = rnd + 4'(i);
        assign rcon  = rcon_of(r_idx);

        aes_key_step u_key_step (
            .rk      (rk_chain[i]),
            .rcon    (rcon),
            .rk_next (rk_chain[i+1])
        );

        aes_sub_bytes u_sub_bytes (
            .din  (st_chain[i]),
            .dout (sb)
        );

        aes_shift_rows u_shift_rows (
            .din  (sb),
            .dout (sr)
        );

        aes_mix_columns u_mix_columns (
            .din  (sr),
            .dout (mc)
        );

        // Round 10 skips MixColumns; selection is by absolute round index.
        assign st_chain[i+1] = ((r_idx == 4'(NR)) ? sr : mc) ^ rk_chain[i+1];
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_step) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers: block capture, per-cycle round advance, result latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= '0;
            rk_reg    <= '0;
            rnd       <= '0;
            out_ct    <= '0;
        end else begin
            if (load) begin
                state_reg <= in_pt ^ in_key;
                rk_reg    <= in_key;
                rnd       <= 4'd1;
            end
            if (step) begin
                state_reg <= st_chain[UNROLL];
                rk_reg    <= rk_chain[UNROLL];
                if (!finish) begin
                    rnd <= rnd + 4'(UNROLL);
                end
            end
            if (finish) begin
                out_ct <= st_chain[UNROLL];
            end
        end
    end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Bench: four cores (UNROLL 1/2/5/10) on shared stimulus, checked against a byte-level AES model.
module tb_aes128_enc_iter;

    localparam int NI = 4;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_pt;
    logic [127:0] in_key;

    logic         in_ready_v  [NI];
    logic         out_valid_v [NI];
    logic         busy_v      [NI];
    logic [127:0] out_ct_v    [NI];

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]   sb [256];
    int           nit [NI] = '{10, 5, 2, 1};
    logic         m_busy  [NI];
    logic         m_valid [NI];
    int           m_cnt   [NI];
    logic [127:0] m_ct    [NI];
    logic [127:0] m_pend  [NI];

    logic         stim_done = 1'b0;
    logic         lit_on    = 1'b0;
    logic [127:0] lit_exp   = '0;

    always #5 clk = ~clk;

    aes128_enc_iter #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_pt(in_pt), .in_key(in_key), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .out_ct(out_ct_v[0]), .busy(busy_v[0]));

    aes128_enc_iter #(.UNROLL(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_pt(in_pt), .in_key(in_key), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .out_ct(out_ct_v[1]), .busy(busy_v[1]));

    aes128_enc_iter #(.UNROLL(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_pt(in_pt), .in_key(in_key), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .out_ct(out_ct_v[2]), .busy(busy_v[2]));

    aes128_enc_iter #(.UNROLL(10)) u_dut10 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[3]),
        .in_pt(in_pt), .in_key(in_key), .out_valid(out_valid_v[3]),
        .out_ready(out_ready), .out_ct(out_ct_v[3]), .busy(busy_v[3]));

    // GF(2^8) arithmetic used to derive the S-box from its definition.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < n; i++) y = {y[6:0], y[7]};
        return y;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return gmul(b, 8'h02);
    endfunction

    // Reference encryption on byte arrays with a fully expanded key schedule.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                a0 = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[a0];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++)
                    s[rw + 4*c] = t[rw + 4*((c + rw) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string nm, input int k, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s [u%0d] got %h required %h", nm, k, got, want);
        end
    endtask

    // Transaction-level model: a core idles, computes for NITER cycles, then holds its result until taken.
    initial begin
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                repeat (254) inv = gmul(inv, 8'(v));
            end
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int k = 0; k < NI; k++) begin
            m_busy[k] = 1'b0; m_valid[k] = 1'b0; m_cnt[k] = 0; m_ct[k] = '0; m_pend[k] = '0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) begin
                if (rst) begin
                    m_busy[k] = 1'b0; m_valid[k] = 1'b0; m_cnt[k] = 0; m_ct[k] = '0;
                end else if (!m_busy[k]) begin
                    if (in_valid) begin
                        m_busy[k] = 1'b1;
                        m_cnt[k]  = nit[k];
                        m_pend[k] = aes_ref(in_pt, in_key);
                    end
                end else if (m_cnt[k] > 0) begin
                    m_cnt[k] = m_cnt[k] - 1;
                    if (m_cnt[k] == 0) begin
                        m_valid[k] = 1'b1;
                        m_ct[k]    = m_pend[k];
                    end
                end else if (out_ready) begin
                    m_valid[k] = 1'b0;
                    m_busy[k]  = 1'b0;
                end
            end
        end
    end

    // Compare process: known-answer pins on the model, then every output every cycle.
    initial begin
        @(negedge clk);
        chk("sbox_00", -1, 128'(sb[8'h00]), 128'h63);
        chk("sbox_53", -1, 128'(sb[8'h53]), 128'hed);
        chk("ref_c1", -1, aes_ref(C1_PT, C1_KEY), C1_CT);
        chk("ref_b", -1, aes_ref(B_PT, B_KEY), B_CT);
        chk("ref_zero", -1, aes_ref('0, '0), Z_CT);
        while (!stim_done) begin
            for (int k = 0; k < NI; k++) begin
                chk("in_ready", k, 128'(in_ready_v[k]), 128'(!m_busy[k]));
                chk("out_valid", k, 128'(out_valid_v[k]), 128'(m_valid[k]));
                chk("busy", k, 128'(busy_v[k]), 128'(m_busy[k]));
                chk("out_ct", k, out_ct_v[k], m_ct[k]);
                if (lit_on && m_valid[k]) chk("known_vector", k, out_ct_v[k], lit_exp);
            end
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic drive(input logic v, input logic [127:0] pt, input logic [127:0] key,
                         input logic ordy, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid  = v;
            in_pt     = pt;
            in_key    = key;
            out_ready = ordy;
            rst       = r;
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus: known vectors, backpressure, back-to-back, resets, then random traffic.
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pt = '0; in_key = '0; out_ready = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b1, 3);

        lit_exp = C1_CT; lit_on = 1'b1;
        drive(1'b1, C1_PT, C1_KEY, 1'b1, 1'b0, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 13);
        lit_exp = B_CT;
        drive(1'b1, B_PT, B_KEY, 1'b1, 1'b0, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 13);
        lit_exp = Z_CT;
        drive(1'b1, '0, '0, 1'b0, 1'b0, 1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 12);
        drive(1'b1, C1_PT, C1_KEY, 1'b0, 1'b0, 1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 4);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 3);
        lit_on = 1'b0;

        for (int i = 0; i < 45; i++) begin
            case (i % 3)
                0:       drive(1'b1, C1_PT, C1_KEY, 1'b1, 1'b0, 1);
                1:       drive(1'b1, B_PT, B_KEY, 1'b1, 1'b0, 1);
                default: drive(1'b1, '0, '0, 1'b1, 1'b0, 1);
            endcase
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 14);

        drive(1'b1, C1_PT, C1_KEY, 1'b1, 1'b0, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 3);
        drive(1'b1, B_PT, B_KEY, 1'b1, 1'b1, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 2);
        lit_exp = C1_CT; lit_on = 1'b1;
        drive(1'b1, C1_PT, C1_KEY, 1'b1, 1'b0, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 13);
        lit_on = 1'b0;

        drive(1'b1, B_PT, B_KEY, 1'b1, 1'b1, 1);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 12);

        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 1)),
                  {$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 63) == 0), 1);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 14);
        stim_done = 1'b1;
    end

endmodule
